// File: rtl/rvr32_ifetch.sv
// rvr32 instruction fetch: issues pipelined imem requests from the shared PC,
// tracks in-flight requests and buffers responses for decode.
module rvr32_ifetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_we,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] disc_cnt;
  logic [CW-1:0] q_cnt;
  logic [PW-1:0] aq_wr;
  logic [PW-1:0] aq_rd;
  logic [PW-1:0] q_wr;
  logic [PW-1:0] q_rd;
  logic [31:0]   aq_mem [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_data [DEPTH];

  logic          accept;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW:0]   inflight;
  logic [CW-1:0] acc_ext;
  logic [CW-1:0] rsp_ext;
  logic [CW-1:0] push_ext;
  logic [CW-1:0] pop_ext;

  assign misalign  = (pc[1:0] != 2'b00);
  assign imem_addr = pc;

  // Registered counts only, so the request never depends on same-cycle grant/response.
  assign inflight = {1'b0, out_cnt} + {1'b0, q_cnt};
  assign imem_req = !rst && !flush && !misalign && (inflight < DEPTH_C);
  assign accept   = imem_req && imem_gnt;
  assign pc_we    = accept;

  assign drop = imem_rvalid && (disc_cnt != '0);
  assign push = imem_rvalid && (disc_cnt == '0) && !flush;
  assign pop  = inst_valid && inst_ready && !flush;

  assign inst_valid = !rst && (q_cnt != '0);
  assign inst_data  = q_data[q_rd];
  assign inst_pc    = q_pc[q_rd];

  assign acc_ext  = {{(CW-1){1'b0}}, accept};
  assign rsp_ext  = {{(CW-1){1'b0}}, imem_rvalid};
  assign push_ext = {{(CW-1){1'b0}}, push};
  assign pop_ext  = {{(CW-1){1'b0}}, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt  <= '0;
      disc_cnt <= '0;
      aq_wr    <= '0;
      aq_rd    <= '0;
    end else begin
      out_cnt <= out_cnt + acc_ext - rsp_ext;
      if (accept) aq_wr <= aq_wr + 1'b1;
      if (imem_rvalid) aq_rd <= aq_rd + 1'b1;
      // Everything still in flight after this cycle's response becomes stale.
      if (flush) disc_cnt <= out_cnt - rsp_ext;
      else if (drop) disc_cnt <= disc_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_cnt <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
    end else if (flush) begin
      q_cnt <= '0;
      q_wr  <= '0;
      q_rd  <= '0;
    end else begin
      q_cnt <= q_cnt + push_ext - pop_ext;
      if (push) q_wr <= q_wr + 1'b1;
      if (pop) q_rd <= q_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) aq_mem[aq_wr] <= pc;
    if (push) begin
      q_pc[q_wr]   <= aq_mem[aq_rd];
      q_data[q_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_rvr32_ifetch.sv
// Self-checking bench for rvr32_ifetch: directed scenarios plus randomized traffic,
// checked against a queue-level model of the expected fetch stream.
module tb_rvr32_ifetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_we;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign;

  rvr32_ifetch #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_we      (pc_we),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t       pend[$];      // granted, memory has not answered yet
  logic [31:0] rdyq[$];      // addresses decode should see next, in order
  logic [31:0] seen[$];
  logic [31:0] seen_data[$];
  int          seen_cyc[$];
  int          epoch;
  int          cyc;
  int          mem_mode;     // 0 random latency, 1 answer when due, 2 hold
  int          n_cmp;
  int          n_bad;
  bit          force_rsp;
  bit          last_we;
  bit          last_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] seen_data_at(input int i);
    return (i < seen_data.size()) ? seen_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int seen_cyc_at(input int i);
    return (i < seen_cyc.size()) ? seen_cyc[i] : -1000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(input bit f, input logic [31:0] tgt, input bit g, input bit r);
    bit    rsp;
    bit    exp_mis;
    bit    exp_req;
    bit    exp_acc;
    pend_t e;
    flush      = f;
    imem_gnt   = g;
    inst_ready = r;
    rsp = (pend.size() != 0) && (pend[0].due <= cyc) &&
          (mem_mode == 1 || force_rsp || (mem_mode == 0 && $urandom_range(0, 3) != 0));
    imem_rvalid = rsp;
    imem_rdata  = rsp ? mem_word(pend[0].addr) : $urandom;
    @(negedge clk);
    exp_mis = (pc[1:0] != 2'b00);
    exp_req = !f && !exp_mis && (pend.size() + rdyq.size() < DEPTH);
    exp_acc = exp_req && g;
    check_eq("misalign", 32'(misalign), 32'(exp_mis));
    check_eq("imem_req", 32'(imem_req), 32'(exp_req));
    check_eq("pc_we", 32'(pc_we), 32'(exp_acc));
    if (exp_req) check_eq("imem_addr", imem_addr, pc);
    check_eq("inst_valid", 32'(inst_valid), 32'(rdyq.size() != 0));
    if (rdyq.size() != 0) begin
      check_eq("inst_pc", inst_pc, rdyq[0]);
      check_eq("inst_data", inst_data, mem_word(rdyq[0]));
    end
    last_we  = pc_we;
    last_req = imem_req;
    if (inst_valid && r && !f) begin
      seen.push_back(inst_pc);
      seen_data.push_back(inst_data);
      seen_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (rdyq.size() != 0 && r && !f) void'(rdyq.pop_front());
    if (rsp) begin
      e = pend.pop_front();
      if (e.epoch == epoch && !f) rdyq.push_back(e.addr);
    end
    if (f) begin
      rdyq.delete();
      epoch++;
    end
    if (exp_acc) pend.push_back('{pc, epoch, cyc + 1});
    if (f) pc = tgt;
    else if (exp_acc) pc = pc + 32'd4;
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst         = 1'b1;
    flush       = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    pc          = start;
    force_rsp   = 1'b0;
    pend.delete();
    rdyq.delete();
    seen.delete();
    seen_data.delete();
    seen_cyc.delete();
    @(posedge clk);
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_pc_we", 32'(pc_we), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int we_cnt;
    int req_cnt;
    int mis_cnt;
    int stale;
    rst = 1'b1;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    epoch = 0;

    // Streaming: one grant and one instruction per cycle.
    do_reset(32'h0);
    mem_mode = 1;
    we_cnt = 0;
    repeat (12) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      we_cnt += int'(last_we);
    end
    check_eq("t1_we_count", 32'(we_cnt), 32'd12);
    check_eq("t1_pc0", seen_at(0), 32'h0);
    check_eq("t1_pc1", seen_at(1), 32'h4);
    check_eq("t1_pc2", seen_at(2), 32'h8);
    check_eq("t1_data0", seen_data_at(0), mem_word(32'h0));
    check_eq("t1_data2", seen_data_at(2), mem_word(32'h8));
    check_eq("t1_back2back", 32'(seen_cyc_at(2) - seen_cyc_at(0)), 32'd2);

    // Back-pressure: DEPTH grants then stall, drain in order, resume.
    do_reset(32'h80);
    mem_mode = 1;
    we_cnt = 0;
    repeat (10) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      we_cnt += int'(last_we);
    end
    check_eq("t2_grants", 32'(we_cnt), 32'd4);
    check_eq("t2_req_low", 32'(last_req), 32'd0);
    we_cnt = 0;
    repeat (10) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      we_cnt += int'(last_we);
    end
    check_eq("t2_drain0", seen_at(0), 32'h80);
    check_eq("t2_drain3", seen_at(3), 32'h8C);
    check_eq("t2_drain_back2back", 32'(seen_cyc_at(3) - seen_cyc_at(0)), 32'd3);
    check_eq("t2_resume", 32'(we_cnt > 0), 32'd1);

    // Flush with two requests outstanding.
    do_reset(32'h10);
    mem_mode = 2;
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h100, 1'b0, 1'b1);
    mem_mode = 1;
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("t3_first_after_flush", seen_at(0), 32'h100);
    check_eq("t3_first_data", seen_data_at(0), mem_word(32'h100));

    // Flush in the same cycle as a response, one more still outstanding.
    do_reset(32'h20);
    mem_mode = 2;
    repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    force_rsp = 1'b1;
    cycle(1'b1, 32'h200, 1'b0, 1'b1);
    force_rsp = 1'b0;
    mem_mode = 1;
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    stale = 0;
    foreach (seen[i]) if (seen[i] == 32'h20 || seen[i] == 32'h24) stale++;
    check_eq("t4_stale", 32'(stale), 32'd0);
    check_eq("t4_first_after_flush", seen_at(0), 32'h200);

    // Misaligned PC never fetches.
    do_reset(32'h102);
    mem_mode = 0;
    we_cnt = 0;
    req_cnt = 0;
    mis_cnt = 0;
    repeat (20) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      we_cnt += int'(last_we);
      req_cnt += int'(last_req);
      mis_cnt += int'(misalign);
    end
    check_eq("t5_we", 32'(we_cnt), 32'd0);
    check_eq("t5_req", 32'(req_cnt), 32'd0);
    check_eq("t5_misalign", 32'(mis_cnt), 32'd20);

    // Asynchronous reset with three buffered instructions.
    do_reset(32'h40);
    mem_mode = 1;
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    flush       = 1'b0;
    imem_gnt    = 1'b1;
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    #2;
    check_eq("t6_pre_valid", 32'(inst_valid), 32'd1);
    check_eq("t6_pre_pc", inst_pc, 32'h40);
    check_eq("t6_pre_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_valid", 32'(inst_valid), 32'd0);
    check_eq("t6_req", 32'(imem_req), 32'd0);
    check_eq("t6_pc_we", 32'(pc_we), 32'd0);

    // Randomized traffic.
    do_reset(32'($urandom_range(0, 63)) << 2);
    mem_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      bit          f;
      f = ($urandom_range(0, 19) == 0);
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 24) == 0) tgt[1] = 1'b1;
      cycle(f, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
